usr_shift_sequencer: RTL
========================

# usr_shift_sequencer

Word-level sequencer that sits directly upstream of the 16-bit universal shift register (USR) and drives its mode, parallel-load and serial-fill inputs. It accepts 16-bit words over a valid/ready handshake and loads each word into the USR with one LOAD_PARALLEL command. It then issues DATA_WIDTH shift commands so the word leaves the USR serial output one bit per cycle, and flags each cycle in which that output carries a valid data bit. Optional hold and back-to-back word acceptance let it feed a continuous serial stream.

## Interface
- DATA_WIDTH, 16, word width; must equal the USR width.
- SHIFT_DIR, 0, 0 = shift right (LSB first, USR right serial output); 1 = shift left (MSB first, USR left serial output).
- FILL_BIT, 1'b0, constant value driven on both serial fill outputs.

- Clk_In  input  1  single clock; all state changes on its rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Word_Data_In  input  DATA_WIDTH  word to serialize.
- Word_Valid_In  input  1  word present on Word_Data_In.
- Word_Ready_Out  output  1  sequencer can accept a word this cycle.
- Hold_In  input  1  pause shifting while high.
- USR_Mode_Out  output  2  to USR mode input: 0 LOAD_PARALLEL, 1 SHIFT_RIGHT, 2 SHIFT_LEFT, 3 NO_CHANGE.
- USR_Parallel_Data_Out  output  DATA_WIDTH  to USR parallel data input.
- USR_Serial_Data_Left_Out  output  1  to USR left serial input; always FILL_BIT.
- USR_Serial_Data_Right_Out  output  1  to USR right serial input; always FILL_BIT.
- Bit_Valid_Out  output  1  USR serial output holds a valid data bit this cycle.
- Bit_Count_Out  output  5  index of the bit currently presented (0..DATA_WIDTH-1).
- Word_Done_Out  output  1  current bit is the last bit of the word.
- Busy_Out  output  1  high in the LOAD and SHIFT states.

## Operation
- **States:** IDLE, LOAD, SHIFT.
- **Holding register:** a word is accepted when Word_Valid_In and Word_Ready_Out are both high at a rising edge. The accepted word is captured into the holding register, which drives USR_Parallel_Data_Out.
- **IDLE**
  - Outputs: Word_Ready_Out=1, USR_Mode_Out=3, Bit_Valid_Out=0.
  - On accept: go to LOAD.
- **LOAD** (exactly 1 cycle; Hold_In is ignored)
  - Outputs: USR_Mode_Out=0, Word_Ready_Out=0.
  - Next state: SHIFT with Bit_Count=0.
- **SHIFT with Hold_In=0**
  - USR_Mode_Out = 1 if SHIFT_DIR=0, else 2.
  - Bit_Valid_Out=1; Bit_Count increments at each edge.
- **SHIFT with Hold_In=1**
  - USR_Mode_Out=3, Bit_Valid_Out=0, Word_Done_Out=0, Word_Ready_Out=0.
  - Bit_Count is frozen.
- **Last bit** (Bit_Count = DATA_WIDTH-1, Hold_In=0)
  - Word_Done_Out=1, Word_Ready_Out=1, USR_Mode_Out=3.
  - Next state is LOAD if a word is accepted that cycle, otherwise IDLE.
  - Bit_Count returns to 0.
- **Bit order:** with SHIFT_DIR=0, bit k of the word is presented at Bit_Count=k; with SHIFT_DIR=1, bit DATA_WIDTH-1-k is presented at Bit_Count=k.
- **Fill:** fill bits shift into the vacated end of the USR; their value is don't-care to consumers.
- **Bit_Count width:** Bit_Count_Out is 5 bits wide and supports DATA_WIDTH up to 32.
- **Output decode:** all outputs are decoded from registered state, except that Hold_In and Word_Valid_In only gate the mode, ready and done outputs as stated above.

## Timing
- **Reset:** while Reset_In=1 and on the cycle after it deasserts, the sequencer is in IDLE with Bit_Count=0 and holding register=0. Output values:
  - USR_Mode_Out=3, USR_Parallel_Data_Out=0.
  - Bit_Valid_Out=0, Word_Done_Out=0, Busy_Out=0, Bit_Count_Out=0.
  - Word_Ready_Out is forced to 0 while Reset_In=1.
- **Reset mid-word:** the word is abandoned with no partial Word_Done_Out, and the next cycle is IDLE.
- **Latency:** accept edge at cycle t → LOAD during t+1 → first Bit_Valid_Out during t+2 → last bit (Word_Done_Out) during t+2+DATA_WIDTH-1.
- **Throughput:** back-to-back words take DATA_WIDTH+1 cycles each (one LOAD bubble between words).
- **Hold:** each Hold_In cycle adds exactly one cycle and never drops or repeats a bit.
- **Busy_Out:** high from the LOAD cycle through the last-bit cycle.

## Test plan
- Reset, DATA_WIDTH=16, SHIFT_DIR=0, accept 16'hA5C3 → one LOAD cycle with USR_Parallel_Data_Out=16'hA5C3. Then 16 Bit_Valid cycles whose USR serial output reads 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; Word_Done_Out=1 only at Bit_Count=15; then IDLE.
- SHIFT_DIR=1, word 16'h8001 → USR_Mode_Out=2 during shifting; serial bits read 1, fourteen 0s, 1.
- Word_Valid_In held high with words 16'h1234 then 16'hFFFF → second word accepted on the last-bit cycle of the first; LOAD follows immediately, with 17 cycles between the two LOAD cycles.
- Hold_In high for 3 cycles at Bit_Count=5 → USR_Mode_Out=3 and Bit_Valid_Out=0 for those cycles; Bit_Count_Out stays 5; the word completes 3 cycles later with the correct bit sequence.
- Reset_In pulsed at Bit_Count=9 → next cycle in IDLE with all outputs at reset values; a new word 16'h00FF then serializes correctly from bit 0.
- Word_Valid_In high while in LOAD or mid-SHIFT → not accepted (Word_Ready_Out=0); the word is taken only in IDLE or on the last-bit cycle.

Source files
------------

// File: rtl/usr_shift_sequencer.sv
// Purpose : serializes valid/ready-accepted words through a 16-bit universal shift register.
// Latency : accept edge t -> LOAD during t+1 -> bit 0 valid during t+2 -> last bit during t+1+DATA_WIDTH.
// Backpr. : Word_Ready_Out only in IDLE or on an unheld last-bit cycle; Hold_In freezes shifting.
//
// Ports:
//   Clk_In, Reset_In            clock and synchronous active-high reset
//   Word_Data_In/_Valid_In      word to serialize, offered with valid
//   Word_Ready_Out              word accepted when valid and ready are both high at an edge
//   Hold_In                     pauses shifting (ignored in LOAD)
//   USR_Mode_Out                0 load, 1 shift right, 2 shift left, 3 no change
//   USR_Parallel_Data_Out       holding register, feeds the USR parallel input
//   USR_Serial_Data_*_Out       constant fill bit into the vacated USR end
//   Bit_Valid_Out               USR serial output carries a data bit this cycle
//   Bit_Count_Out               index of the presented bit
//   Word_Done_Out               presented bit is the last one of the word
//   Busy_Out                    high in LOAD and SHIFT
module usr_shift_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          SHIFT_DIR  = 1'b0,
  parameter logic        FILL_BIT   = 1'b0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Word_Data_In,
  input  logic                  Word_Valid_In,
  output logic                  Word_Ready_Out,
  input  logic                  Hold_In,
  output logic [1:0]            USR_Mode_Out,
  output logic [DATA_WIDTH-1:0] USR_Parallel_Data_Out,
  output logic                  USR_Serial_Data_Left_Out,
  output logic                  USR_Serial_Data_Right_Out,
  output logic                  Bit_Valid_Out,
  output logic [4:0]            Bit_Count_Out,
  output logic                  Word_Done_Out,
  output logic                  Busy_Out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOAD  = 2'd0;
  localparam logic [1:0] MODE_SR    = 2'd1;
  localparam logic [1:0] MODE_SL    = 2'd2;
  localparam logic [1:0] MODE_NC    = 2'd3;
  localparam logic [1:0] MODE_SHIFT = SHIFT_DIR ? MODE_SL : MODE_SR;
  localparam logic [4:0] LAST_CNT   = 5'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic last_bit;
  logic ready;
  logic accept;

  // The last bit only "happens" when it is not held; a held last bit
  // behaves like any other held bit (no done, no ready).
  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT) && !Hold_In;
  assign ready    = !Reset_In && ((state_q == ST_IDLE) || last_bit);
  assign accept   = Word_Valid_In && ready;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 5'd0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_d        = accept ? Word_Data_In : word_q;
    USR_Mode_Out  = MODE_NC;
    Bit_Valid_Out = 1'b0;
    Word_Done_Out = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        USR_Mode_Out = MODE_LOAD;
        state_d      = ST_SHIFT;
        bit_cnt_d    = 5'd0;
      end

      ST_SHIFT: begin
        if (!Hold_In) begin
          Bit_Valid_Out = 1'b1;
          if (last_bit) begin
            // Word fully presented: no further shift needed, so the USR
            // is left untouched while the next word (if any) is loaded.
            Word_Done_Out = 1'b1;
            bit_cnt_d     = 5'd0;
            state_d       = accept ? ST_LOAD : ST_IDLE;
          end else begin
            USR_Mode_Out = MODE_SHIFT;
            bit_cnt_d    = bit_cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  assign Word_Ready_Out            = ready;
  assign USR_Parallel_Data_Out     = word_q;
  assign USR_Serial_Data_Left_Out  = FILL_BIT;
  assign USR_Serial_Data_Right_Out = FILL_BIT;
  assign Bit_Count_Out             = bit_cnt_q;
  assign Busy_Out                  = (state_q != ST_IDLE);

endmodule
